// File: rtl/interp_pkg.sv
// Shared types and helpers for the pilot interpolation stream engine.
package interp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN,
        ST_TAIL
    } state_e;

    localparam logic [1:0] PH0 = 2'd0;
    localparam logic [1:0] PH1 = 2'd1;
    localparam logic [1:0] PH2 = 2'd2;

    // Guard bits on top of IN_WIDTH so that 5*last - 2*pold cannot overflow.
    localparam int SUM_GUARD = 3;

    function automatic logic signed [63:0] sat_to_out(input logic signed [63:0] v, input int ow);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/interp_stream_engine_div3_round.sv
// Combinational q = floor((sum+1)/3) with saturation to OUT_WIDTH signed.
module div3_round
    import interp_pkg::*;
#(
    parameter int SUM_WIDTH = 20,
    parameter int OUT_WIDTH = 17
) (
    input  logic signed [SUM_WIDTH-1:0] sum,
    output logic signed [OUT_WIDTH-1:0] q
);

    logic signed [63:0] num;
    logic signed [63:0] quo;

    always_comb begin
        num = 64'(sum) + 64'sd1;
        quo = num / 64'sd3;
        // Division truncates toward zero; step down for inexact negatives to get floor.
        if (num < 64'sd0 && (quo * 64'sd3) != num) quo = quo - 64'sd1;
        q = OUT_WIDTH'(sat_to_out(quo, OUT_WIDTH));
    end

endmodule

// File: rtl/interp_stream_engine.sv
// Self-sequenced pilot interpolator: N_PILOT pilots in, 3*N_PILOT samples out.
// Define EDGE_EXTRAP_EN to extrapolate the tail from the last two pilots.
module interp_stream_engine
    import interp_pkg::*;
#(
    parameter int IN_WIDTH  = 17,
    parameter int OUT_WIDTH = 17,
    parameter int N_PILOT   = 4,
    parameter int IDX_WIDTH = $clog2(3 * N_PILOT)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [IN_WIDTH-1:0]  in_r,
    input  logic signed [IN_WIDTH-1:0]  in_i,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] out_r,
    output logic signed [OUT_WIDTH-1:0] out_i,
    output logic [IDX_WIDTH-1:0]        out_idx,
    output logic                        out_last
);

    localparam int SUM_WIDTH  = IN_WIDTH + SUM_GUARD;
    localparam int PCNT_WIDTH = $clog2(N_PILOT + 1);

    state_e                      state_q, state_d;
    logic [1:0]                  phase_q, phase_d;
    logic [PCNT_WIDTH-1:0]       pcnt_q, pcnt_d;
    logic signed [IN_WIDTH-1:0]  prev_q [2];
    logic signed [IN_WIDTH-1:0]  prev_d [2];
    logic signed [IN_WIDTH-1:0]  next_q [2];
    logic signed [IN_WIDTH-1:0]  next_d [2];
`ifdef EDGE_EXTRAP_EN
    logic signed [IN_WIDTH-1:0]  pold_q [2];
    logic signed [IN_WIDTH-1:0]  pold_d [2];
`endif
    logic                        in_ready_q, in_ready_d;
    logic                        out_valid_q, out_valid_d;
    logic                        out_last_q, out_last_d;
    logic signed [OUT_WIDTH-1:0] out_r_q, out_r_d;
    logic signed [OUT_WIDTH-1:0] out_i_q, out_i_d;
    logic [IDX_WIDTH-1:0]        out_idx_q, out_idx_d;

    logic signed [SUM_WIDTH-1:0] sum [2];
    logic signed [OUT_WIDTH-1:0] quo [2];
    logic [IDX_WIDTH-1:0]        idx_cur;
    int                          seg;
    logic                        accept;
    logic                        adv;

    // Every output goes through the divider; plain copies are fed in as 3*x.
    always_comb begin
        logic signed [SUM_WIDTH-1:0] a;
        logic signed [SUM_WIDTH-1:0] b;
`ifdef EDGE_EXTRAP_EN
        logic signed [SUM_WIDTH-1:0] o;
`endif
        for (int p = 0; p < 2; p++) begin
            a = SUM_WIDTH'(prev_q[p]);
            b = SUM_WIDTH'(next_q[p]);
            sum[p] = a + a + a;
            if (state_q == ST_RUN) begin
                if (phase_q == PH1)      sum[p] = a + a + b;
                else if (phase_q == PH2) sum[p] = a + b + b;
            end
`ifdef EDGE_EXTRAP_EN
            o = SUM_WIDTH'(pold_q[p]);
            if (state_q == ST_TAIL) begin
                if (phase_q == PH1)      sum[p] = (a <<< 2) - o;
                else if (phase_q == PH2) sum[p] = (a <<< 2) + a - o - o;
            end
`endif
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_div
        div3_round #(
            .SUM_WIDTH (SUM_WIDTH),
            .OUT_WIDTH (OUT_WIDTH)
        ) u_div3 (
            .sum (sum[g]),
            .q   (quo[g])
        );
    end

    // Segment k covers pilots k..k+1; in TAIL prev already holds the last pilot.
    always_comb begin
        seg     = (state_q == ST_TAIL) ? int'(pcnt_q) - 1 : int'(pcnt_q) - 2;
        idx_cur = IDX_WIDTH'(3 * seg + int'(phase_q));
    end

    assign accept = in_valid && in_ready_q;
    assign adv    = !out_valid_q || out_ready;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        pcnt_d      = pcnt_q;
        prev_d      = prev_q;
        next_d      = next_q;
`ifdef EDGE_EXTRAP_EN
        pold_d      = pold_q;
`endif
        out_valid_d = out_valid_q && !out_ready;
        out_last_d  = out_last_q && !out_ready;
        out_r_d     = out_r_q;
        out_i_d     = out_i_q;
        out_idx_d   = out_idx_q;

        case (state_q)
            ST_IDLE: if (accept) begin
                prev_d[0] = in_r;
                prev_d[1] = in_i;
                pcnt_d    = PCNT_WIDTH'(1);
                state_d   = ST_FILL;
            end
            ST_FILL: if (accept) begin
                next_d[0] = in_r;
                next_d[1] = in_i;
                pcnt_d    = pcnt_q + PCNT_WIDTH'(1);
                phase_d   = PH0;
                state_d   = ST_RUN;
            end
            ST_RUN: if (adv) begin
                out_valid_d = 1'b1;
                out_last_d  = 1'b0;
                out_r_d     = quo[0];
                out_i_d     = quo[1];
                out_idx_d   = idx_cur;
                if (phase_q == PH2) begin
                    phase_d = PH0;
`ifdef EDGE_EXTRAP_EN
                    pold_d  = prev_q;
`endif
                    prev_d  = next_q;
                    state_d = (pcnt_q == PCNT_WIDTH'(N_PILOT)) ? ST_TAIL : ST_FILL;
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end
            ST_TAIL: if (adv) begin
                out_valid_d = 1'b1;
                out_last_d  = (phase_q == PH2);
                out_r_d     = quo[0];
                out_i_d     = quo[1];
                out_idx_d   = idx_cur;
                if (phase_q == PH2) begin
                    phase_d = PH0;
                    pcnt_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // flush wins over any handshake in the same cycle, including a pilot accept.
        if (flush) begin
            state_d     = ST_IDLE;
            phase_d     = PH0;
            pcnt_d      = '0;
            prev_d      = prev_q;
            next_d      = next_q;
`ifdef EDGE_EXTRAP_EN
            pold_d      = pold_q;
`endif
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        in_ready_d = (state_d == ST_IDLE) || (state_d == ST_FILL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH0;
            pcnt_q      <= '0;
            prev_q      <= '{default: '0};
            next_q      <= '{default: '0};
`ifdef EDGE_EXTRAP_EN
            pold_q      <= '{default: '0};
`endif
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_r_q     <= '0;
            out_i_q     <= '0;
            out_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            pcnt_q      <= pcnt_d;
            prev_q      <= prev_d;
            next_q      <= next_d;
`ifdef EDGE_EXTRAP_EN
            pold_q      <= pold_d;
`endif
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_r_q     <= out_r_d;
            out_i_q     <= out_i_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_r     = out_r_q;
    assign out_i     = out_i_q;
    assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_interp_stream_engine.sv
// Randomized stream bench for interp_stream_engine against a block-level reference model.
module tb_interp_stream_engine;

    localparam int IW = 17;
    localparam int OW = 17;
    localparam int NP = 4;
    localparam int XW = $clog2(3 * NP);
    localparam int OMAX = (1 << (OW - 1)) - 1;
    localparam int OMIN = -(1 << (OW - 1));

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic signed [IW-1:0] in_r = '0;
    logic signed [IW-1:0] in_i = '0;
    logic in_ready, out_valid, out_last;
    logic signed [OW-1:0] out_r, out_i;
    logic [XW-1:0] out_idx;

    int n_checks = 0;
    int n_errors = 0;
    int blk [2][NP];
    int pq_r[$], pq_i[$], eq_r[$], eq_i[$], eq_idx[$];
    bit eq_last[$];
    bit acc_pend = 1'b0;

    interp_stream_engine #(
        .IN_WIDTH (IW), .OUT_WIDTH (OW), .N_PILOT (NP), .IDX_WIDTH (XW)
    ) dut (
        .clk (clk), .rst (rst), .flush (flush),
        .in_valid (in_valid), .in_ready (in_ready), .in_r (in_r), .in_i (in_i),
        .out_valid (out_valid), .out_ready (out_ready), .out_r (out_r), .out_i (out_i),
        .out_idx (out_idx), .out_last (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Rounded third of s, computed in real arithmetic, then clamped.
    function automatic int rnd3(input int s);
        int v;
        v = int'($floor(real'(s + 1) / 3.0));
        if (v > OMAX) v = OMAX;
        if (v < OMIN) v = OMIN;
        return v;
    endfunction

    function automatic int model(input int part, input int j);
        int k, ph, a, b, last, pold;
        k = j / 3;
        ph = j % 3;
        if (k < NP - 1) begin
            a = blk[part][k];
            b = blk[part][k + 1];
            if (ph == 0) return a;
            if (ph == 1) return rnd3(2 * a + b);
            return rnd3(a + 2 * b);
        end
        last = blk[part][NP - 1];
        pold = blk[part][NP - 2];
        if (ph == 0) return last;
`ifdef EDGE_EXTRAP_EN
        if (ph == 1) return rnd3(4 * last - pold);
        return rnd3(5 * last - 2 * pold);
`else
        if (pold == pold) return last;
        return last;
`endif
    endfunction

    task automatic queue_block();
        for (int k = 0; k < NP; k++) begin
            pq_r.push_back(blk[0][k]);
            pq_i.push_back(blk[1][k]);
        end
        for (int j = 0; j < 3 * NP; j++) begin
            eq_r.push_back(model(0, j));
            eq_i.push_back(model(1, j));
            eq_idx.push_back(j);
            eq_last.push_back(j == 3 * NP - 1);
        end
    endtask

    task automatic clear_queues();
        pq_r.delete(); pq_i.delete();
        eq_r.delete(); eq_i.delete(); eq_idx.delete(); eq_last.delete();
    endtask

    // Drives pilots and drains outputs; returns once idx stop_idx is handed over,
    // or when everything queued has been consumed.
    task automatic stream(input int vld_pct, input int rdy_pct, input int stop_idx, input int stall_idx);
        int cyc = 0;
        int stall = 0;
        bit stalled_once = 1'b0;
        bit done = 1'b0;
        bit hold = 1'b0;
        longint h_r = 0, h_i = 0, h_idx = 0;
        while (!done && (pq_r.size() > 0 || eq_r.size() > 0) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (acc_pend) begin
                in_valid = 1'b0;
                acc_pend = 1'b0;
            end
            if (!in_valid && pq_r.size() > 0 && $urandom_range(99) < vld_pct) begin
                in_valid = 1'b1;
                in_r = IW'(pq_r[0]);
                in_i = IW'(pq_i[0]);
            end
            out_ready = ($urandom_range(99) < rdy_pct);
            if (out_valid && int'(out_idx) == stall_idx && !stalled_once) begin
                out_ready = 1'b0;
                stall++;
                if (stall == 5) stalled_once = 1'b1;
                check("stall_in_ready", in_ready, 0);
                if (eq_r.size() > 0) check("stall_r", out_r, eq_r[0]);
            end
            #1;
            if (hold) begin
                check("hold_valid", out_valid, 1);
                check("hold_r", out_r, h_r);
                check("hold_i", out_i, h_i);
                check("hold_idx", out_idx, h_idx);
            end
            hold = out_valid && !out_ready;
            h_r = out_r;
            h_i = out_i;
            h_idx = out_idx;
            if (in_valid && in_ready) begin
                void'(pq_r.pop_front());
                void'(pq_i.pop_front());
                acc_pend = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (eq_r.size() == 0) begin
                    check("extra_out", 1, 0);
                end else begin
                    check("out_r", out_r, eq_r.pop_front());
                    check("out_i", out_i, eq_i.pop_front());
                    check("out_idx", out_idx, eq_idx.pop_front());
                    check("out_last", out_last, eq_last.pop_front());
                    if (int'(out_idx) == stop_idx) done = 1'b1;
                end
            end
        end
        if (cyc >= 5000) check("stream_timeout", eq_r.size() + pq_r.size(), 0);
    endtask

    task automatic ramp_block();
        blk[0] = '{300, 600, 0, -300};
        blk[1] = '{0, 0, 0, 0};
        queue_block();
    endtask

    task automatic random_block();
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < NP; k++) begin
                if ($urandom_range(3) == 0) blk[p][k] = $urandom_range(1) ? OMAX : OMIN;
                else blk[p][k] = int'($urandom_range(131071)) - 65536;
            end
        queue_block();
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_r", out_r, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_last", out_last, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("in_ready_after_rst", in_ready, 1);

        ramp_block();
        stream(100, 100, -1, -1);

        // Rounding corners on both paths
        blk[0] = '{0, 1, 0, -1};
        blk[1] = '{5, -5, 0, 0};
        queue_block();
        stream(100, 100, -1, -1);

        // Backpressure at idx 4
        ramp_block();
        stream(100, 100, -1, 4);

        // Saturation-prone extremes
        blk[0] = '{0, 0, -65536, 65535};
        blk[1] = '{-65536, 65535, -65536, 65535};
        queue_block();
        stream(80, 80, -1, -1);

        // Flush after idx 5
        ramp_block();
        stream(100, 100, 5, -1);
        @(negedge clk);
        in_valid = 1'b0;
        acc_pend = 1'b0;
        out_ready = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        clear_queues();
        random_block();
        stream(100, 100, -1, -1);

        // Asynchronous reset mid-block
        ramp_block();
        stream(100, 100, 2, -1);
        @(negedge clk);
        in_valid = 1'b0;
        acc_pend = 1'b0;
        rst = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 0);
        check("arst_out_r", out_r, 0);
        check("arst_out_i", out_i, 0);
        check("arst_out_idx", out_idx, 0);
        check("arst_out_last", out_last, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        clear_queues();
        ramp_block();
        stream(100, 100, -1, -1);

        // Back-to-back random blocks with random handshakes
        for (int b = 0; b < 15; b++) random_block();
        stream(60, 70, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
